// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter
//
// Round-robin owner selection for a bus shared by four 74LS125-style
// tristate drivers. It produces a registered one-hot grant and the matching
// active-low buffer enables. Between two owners it inserts a dead interval of
// TURN cycles with every buffer disabled, so two drivers are never enabled in
// the same cycle even though the buffer models have no disable delay.
//
// Parameters
//   TURN  turnaround length in cycles (1..7)
//   MAXT  maximum tenure while another requester waits (1..255); only used
//         when the timeout feature is compiled in
//
// Optional feature
//   `define TRISTATE_ARB_TIMEOUT_EN  forces a release once an owner has held
//   the bus for MAXT cycles while some other request is pending
//
// Ports
//   clk    rising-edge clock
//   clr_n  asynchronous active-low reset
//   req    per-driver level request, active-high
//   gnt    registered one-hot grant
//   oe_n   buffer enables for the `c` pins, always ~gnt
//   busy   high while any grant bit is set

module tristate_bus_arbiter #(
   parameter int TURN = 1,
   parameter int MAXT = 8
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [3:0] oe_n,
   output logic       busy
);

   // Illegal parameter values are rejected when the design is elaborated.
   if (TURN < 1 || TURN > 7) begin : g_bad_turn
      $error("tristate_bus_arbiter: TURN must be 1..7");
   end
   if (MAXT < 1 || MAXT > 255) begin : g_bad_maxt
      $error("tristate_bus_arbiter: MAXT must be 1..255");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] owner_q, owner_d;
   logic [1:0] ptr_q, ptr_d;
   logic [2:0] turn_cnt_q, turn_cnt_d;
   logic       busy_q, busy_d;
`ifdef TRISTATE_ARB_TIMEOUT_EN
   logic [7:0] tenure_q, tenure_d;
`endif

   logic       found;
   logic [1:0] win;
   logic [1:0] idx;
   logic       grant_now;
   logic       release_now;

   // Priority scan starting at the round-robin pointer, wrapping mod 4.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      idx   = '0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr_q + 2'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // Next-state logic. Grant and release are decided as flags first and then
   // applied once, so IDLE and the end of TURN share one grant path.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      owner_d     = owner_q;
      ptr_d       = ptr_q;
      turn_cnt_d  = turn_cnt_q;
`ifdef TRISTATE_ARB_TIMEOUT_EN
      tenure_d    = tenure_q;
`endif
      grant_now   = 1'b0;
      release_now = 1'b0;

      case (state_q)
         ST_IDLE: begin
            grant_now = found;
         end
         ST_GRANT: begin
            release_now = !req[owner_q];
`ifdef TRISTATE_ARB_TIMEOUT_EN
            if (tenure_q == 8'(MAXT) && |(req & ~gnt_q)) begin
               release_now = 1'b1;
            end
            if (!release_now && tenure_q != 8'hFF) begin
               tenure_d = tenure_q + 8'd1;
            end
`endif
         end
         ST_TURN: begin
            if (turn_cnt_q != 3'd0) begin
               turn_cnt_d = turn_cnt_q - 3'd1;
            end else if (found) begin
               grant_now = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
         end
      endcase

      if (grant_now) begin
         gnt_d   = 4'b0001 << win;
         owner_d = win;
         state_d = ST_GRANT;
`ifdef TRISTATE_ARB_TIMEOUT_EN
         tenure_d = 8'd1;
`endif
      end

      // The dead interval is TURN cycles: TURN-1 countdown cycles plus the
      // cycle in which the counter is found at zero and arbitration happens.
      if (release_now) begin
         gnt_d      = 4'b0000;
         ptr_d      = owner_q + 2'd1;
         turn_cnt_d = 3'(TURN - 1);
         state_d    = ST_TURN;
      end

      busy_d = |gnt_d;
   end

   // State register. Reset clears the grant asynchronously so every buffer is
   // disabled the moment clr_n falls, without waiting for a clock edge.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= 4'b0000;
         owner_q    <= 2'd0;
         ptr_q      <= 2'd0;
         turn_cnt_q <= 3'd0;
         busy_q     <= 1'b0;
`ifdef TRISTATE_ARB_TIMEOUT_EN
         tenure_q   <= 8'd0;
`endif
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         turn_cnt_q <= turn_cnt_d;
         busy_q     <= busy_d;
`ifdef TRISTATE_ARB_TIMEOUT_EN
         tenure_q   <= tenure_d;
`endif
      end
   end

   assign gnt  = gnt_q;
   assign oe_n = ~gnt_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed testbench for tristate_bus_arbiter built with TURN=2, MAXT=4.
// Inputs change and outputs are sampled 1 time unit after a rising edge.

module tb_tristate_bus_arbiter;

   logic       clk;
   logic       clr_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [3:0] oe_n;
   logic       busy;
   logic       clk_en;

   int vectors;
   int miscompares;

   tristate_bus_arbiter #(
      .TURN(2),
      .MAXT(4)
   ) dut (
      .clk  (clk),
      .clr_n(clr_n),
      .req  (req),
      .gnt  (gnt),
      .oe_n (oe_n),
      .busy (busy)
   );

   // Clock is gated so the reset check can run with no edges at all.
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   // Drive a new request vector and advance the given number of rising edges.
   task automatic applyStimulus(input logic [3:0] req_val, input int cycles);
      req = req_val;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Compare grant, enables and busy against the expected owner vector.
   task automatic checkOutput(input string tag, input logic [3:0] exp_gnt);
      logic [3:0] exp_oe;
      logic       exp_busy;
      exp_oe   = ~exp_gnt;
      exp_busy = |exp_gnt;
      vectors++;
      assert (gnt === exp_gnt) else begin
         miscompares++;
         $error("[TB] FAIL %s gnt: got %b expected %b", tag, gnt, exp_gnt);
      end
      vectors++;
      assert (oe_n === exp_oe) else begin
         miscompares++;
         $error("[TB] FAIL %s oe_n: got %b expected %b", tag, oe_n, exp_oe);
      end
      vectors++;
      assert (busy === exp_busy) else begin
         miscompares++;
         $error("[TB] FAIL %s busy: got %b expected %b", tag, busy, exp_busy);
      end
   endtask

   // Short reset pulse between edges; returns the arbiter to IDLE with ptr=0.
   task automatic pulseReset();
      req   = 4'b0000;
      clr_n = 1'b0;
      #2;
      clr_n = 1'b1;
   endtask

   initial begin
      logic [3:0] rr_req;
      vectors     = 0;
      miscompares = 0;
      clk         = 1'b0;
      clk_en      = 1'b0;
      clr_n       = 1'b1;
      req         = 4'b0000;

      // Reset with every request high and no clock running.
      #2;
      req   = 4'hF;
      clr_n = 1'b0;
      #1;
      checkOutput("reset_no_clock", 4'b0000);
      req   = 4'b0000;
      #2;
      clr_n = 1'b1;
      clk_en = 1'b1;
      applyStimulus(4'b0000, 1);
      checkOutput("idle_after_reset", 4'b0000);

      // Single request from IDLE, then release.
      applyStimulus(4'b0100, 1);
      checkOutput("single_grant", 4'b0100);
      applyStimulus(4'b0000, 1);
      checkOutput("single_release", 4'b0000);
      applyStimulus(4'b0000, 2);
      checkOutput("single_back_idle", 4'b0000);

      // Round robin: every owner holds 3 cycles then drops for 1 cycle.
      $display("[TB] round-robin sequence");
      pulseReset();
      rr_req = 4'hF;
      applyStimulus(rr_req, 1);
      checkOutput("rr_first_owner0", 4'b0001);
      for (int w = 0; w < 4; w++) begin
         applyStimulus(rr_req, 1);
         checkOutput("rr_hold2", 4'b0001 << w);
         applyStimulus(rr_req, 1);
         checkOutput("rr_hold3", 4'b0001 << w);
         rr_req[w] = 1'b0;
         applyStimulus(rr_req, 1);
         checkOutput("rr_dead1", 4'b0000);
         rr_req[w] = 1'b1;
         applyStimulus(rr_req, 1);
         checkOutput("rr_dead2", 4'b0000);
         applyStimulus(rr_req, 1);
         checkOutput("rr_next_owner", 4'b0001 << ((w + 1) % 4));
      end
      applyStimulus(4'b0000, 1);
      checkOutput("rr_final_release", 4'b0000);
      applyStimulus(4'b0000, 2);

      // Two steady requesters: timeout rotates the bus only when compiled in.
      $display("[TB] tenure limit with two requesters");
      pulseReset();
      applyStimulus(4'b0011, 1);
      checkOutput("to_grant0", 4'b0001);
`ifdef TRISTATE_ARB_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0011, 1);
         checkOutput("to_hold0", 4'b0001);
      end
      applyStimulus(4'b0011, 1);
      checkOutput("to_forced_dead1", 4'b0000);
      applyStimulus(4'b0011, 1);
      checkOutput("to_forced_dead2", 4'b0000);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b0011, 1);
         checkOutput("to_hold1", 4'b0010);
      end
      applyStimulus(4'b0011, 1);
      checkOutput("to_forced_dead3", 4'b0000);
`else
      for (int i = 0; i < 24; i++) begin
         applyStimulus(4'b0011, 1);
         checkOutput("no_to_hold0", 4'b0001);
      end
`endif
      applyStimulus(4'b0000, 3);

      // Lone requester keeps the bus indefinitely in every build.
      $display("[TB] lone requester");
      pulseReset();
      applyStimulus(4'b0001, 1);
      checkOutput("lone_grant", 4'b0001);
      for (int i = 0; i < 24; i++) begin
         applyStimulus(4'b0001, 1);
         checkOutput("lone_hold", 4'b0001);
      end
      applyStimulus(4'b0000, 3);

      // Reset mid-tenure clears enables with no edge, then ptr restarts at 0.
      $display("[TB] mid-tenure reset");
      pulseReset();
      applyStimulus(4'b1000, 1);
      checkOutput("mid_grant3", 4'b1000);
      applyStimulus(4'b1000, 2);
      checkOutput("mid_hold3", 4'b1000);
      req   = 4'b1001;
      clr_n = 1'b0;
      #1;
      checkOutput("mid_reset_async", 4'b0000);
      #1;
      clr_n = 1'b1;
      applyStimulus(4'b1001, 1);
      checkOutput("mid_first_grant", 4'b0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
